// File: rtl/kgp_dmem_responder.sv
// Data-memory responder for the KGP MiniRISC core: accepts one load/store at a time,
// inserts fixed wait states, and answers with a registered one-cycle ready pulse.
module kgp_dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] lat_waddr_q, lat_waddr_d;
    logic [31:0]       lat_wdata_q, lat_wdata_d;
    logic              lat_write_q, lat_write_d;
    logic              lat_err_q, lat_err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              req_valid;
    logic              req_err;
    logic              cur_write;
    logic              cur_err;
    logic [ADDR_W-1:0] cur_waddr;
    logic [31:0]       cur_wdata;
    logic              ram_we;
    logic [31:0]       ram [DEPTH];

    assign req_valid = mem_read | mem_write;
    assign req_err   = (mem_read & mem_write)
                     | (addr[1:0] != 2'b00)
                     | (addr[31:ADDR_W+2] != '0);

    // In IDLE the live bus is the request (zero-wait accept enters RESP directly);
    // afterwards only the latched copy is trusted.
    always_comb begin
        if (state_q == IDLE) begin
            cur_write = mem_write;
            cur_err   = req_err;
            cur_waddr = addr[ADDR_W+1:2];
            cur_wdata = wdata;
        end else begin
            cur_write = lat_write_q;
            cur_err   = lat_err_q;
            cur_waddr = lat_waddr_q;
            cur_wdata = lat_wdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_waddr_d = lat_waddr_q;
        lat_wdata_d = lat_wdata_q;
        lat_write_d = lat_write_q;
        lat_err_d   = lat_err_q;
        rdata_d     = '0;
        ready_d     = 1'b0;
        err_d       = 1'b0;
        busy_d      = busy_q;
        ram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lat_waddr_d = cur_waddr;
                    lat_wdata_d = cur_wdata;
                    lat_write_d = cur_write;
                    lat_err_d   = cur_err;
                    busy_d      = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        err_d   = cur_err;
                        ram_we  = cur_write & ~cur_err;
                        rdata_d = (cur_write | cur_err) ? 32'd0 : ram[cur_waddr];
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    err_d   = cur_err;
                    ram_we  = cur_write & ~cur_err;
                    rdata_d = (cur_write | cur_err) ? 32'd0 : ram[cur_waddr];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lat_waddr_q <= '0;
            lat_wdata_q <= 32'd0;
            lat_write_q <= 1'b0;
            lat_err_q   <= 1'b0;
            rdata_q     <= 32'd0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_waddr_q <= lat_waddr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_write_q <= lat_write_d;
            lat_err_q   <= lat_err_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    // RAM is deliberately not reset; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram[cur_waddr] <= cur_wdata;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_kgp_dmem_responder.sv
// Scoreboard bench for kgp_dmem_responder: stimulus pushes expected responses,
// a negedge monitor pops and checks them whenever ready is presented.
module tb_kgp_dmem_responder;
    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          checkRdata;
        int          acceptEdge;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   edgeCount  = 0;
    int   respCount  = 0;

    kgp_dmem_responder #(
        .ADDR_W      (10),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Inputs change one time unit after the falling edge, after the monitor has run.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic waitResponse(input string name);
        int startCount = respCount;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (respCount != startCount) return;
        end
        compared++;
        mismatched++;
        $display("[TB] FAIL %s_timeout: got no ready in 30 cycles, required ready=1", name);
        expQ.delete();
    endtask

    task automatic pushExp(input logic [31:0] expRdata, input logic expErr, input bit chk, input int acceptEdge);
        exp_t e;
        e.rdata      = expRdata;
        e.err        = expErr;
        e.checkRdata = chk;
        e.acceptEdge = acceptEdge;
        expQ.push_back(e);
    endtask

    // Issue one request from an IDLE responder, hold it until ready, then drop it.
    task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] expRdata, input logic expErr);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        pushExp(expRdata, expErr, rd & ~wr, edgeCount + 1);
        waitResponse(name);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ready === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_ready: got ready=1, required ready=0 (t=%0t)", $time);
            end else begin
                e = expQ.pop_front();
                checkOutput("latency", 64'(edgeCount - e.acceptEdge), 64'(WAIT_CYCLES));
                checkOutput("err", 64'(err), 64'(e.err));
                if (e.checkRdata) checkOutput("rdata", 64'(rdata), 64'(e.rdata));
                checkOutput("busy_with_ready", 64'(busy), 64'd1);
            end
            respCount++;
        end else if (!rst && ready === 1'b0) begin
            checkOutput("quiet_err_rdata", {31'd0, err, rdata}, 64'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        repeat (2) tick();
        checkOutput("reset_ready", 64'(ready), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_rdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        tick();

        $display("[TB] store then load");
        applyStimulus("wr_10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        applyStimulus("rd_10", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

        $display("[TB] misaligned");
        applyStimulus("rd_12", 1'b1, 1'b0, 32'h0000_0012, 32'h0, 32'h0, 1'b1);
        applyStimulus("rd_10b", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

        $display("[TB] out of range and conflict");
        applyStimulus("wr_00", 1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, 1'b0);
        applyStimulus("wr_20", 1'b0, 1'b1, 32'h0000_0020, 32'h2222_2222, 32'h0, 1'b0);
        applyStimulus("wr_1000", 1'b0, 1'b1, 32'h0000_1000, 32'h5555_5555, 32'h0, 1'b1);
        applyStimulus("rdwr_20", 1'b1, 1'b1, 32'h0000_0020, 32'h9999_9999, 32'h0, 1'b1);
        applyStimulus("rd_00", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, 1'b0);
        applyStimulus("rd_20", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h2222_2222, 1'b0);

        $display("[TB] back-to-back with held requests");
        applyStimulus("wr_88", 1'b0, 1'b1, 32'h0000_0088, 32'h8888_8888, 32'h0, 1'b0);
        mem_write = 1'b1;
        addr      = 32'h0000_0080;
        wdata     = 32'hAAAA_0001;
        pushExp(32'h0, 1'b0, 1'b0, edgeCount + 1);
        waitResponse("b2b_a");
        addr  = 32'h0000_0084;
        wdata = 32'hBBBB_0002;
        pushExp(32'h0, 1'b0, 1'b0, edgeCount + 2);
        tick();
        tick();
        addr  = 32'h0000_0088;
        wdata = 32'hCCCC_0003;
        waitResponse("b2b_b");
        mem_write = 1'b0;
        tick();
        applyStimulus("rd_80", 1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'hAAAA_0001, 1'b0);
        applyStimulus("rd_84", 1'b1, 1'b0, 32'h0000_0084, 32'h0, 32'hBBBB_0002, 1'b0);
        applyStimulus("rd_88", 1'b1, 1'b0, 32'h0000_0088, 32'h0, 32'h8888_8888, 1'b0);

        $display("[TB] reset mid-operation");
        applyStimulus("wr_40_zero", 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 32'h0, 1'b0);
        mem_write = 1'b1;
        addr      = 32'h0000_0040;
        wdata     = 32'h1234_5678;
        tick();
        rst       = 1'b1;
        mem_write = 1'b0;
        tick();
        checkOutput("midrst_ready", 64'(ready), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_err", 64'(err), 64'd0);
        rst = 1'b0;
        repeat (6) tick();
        applyStimulus("rd_40", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0000, 1'b0);

        repeat (4) tick();
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
